life_gen_ctrl: RTL and testbench
================================

Name: life_gen_ctrl

Overview:
- Sequences one Game-of-Life generation over a GP_W x GP_H single-bit cell grid.
- Reads the current buffer through a 1-cycle-latency RAM read port and counts the 8 neighbours of each cell.
- Applies the birth/survival range rule and writes the next state to the next buffer.
- Sits between the frame-buffer RAMs and the top-level generation timer. The timer pulses start; the buffer swap is external.

Parameters:
- GP_W, 16, grid width in cells (>=3)
- GP_H, 16, grid height in cells (>=3)
- GP_BIRTH_MIN, 3, min neighbour count giving birth to a dead cell
- GP_BIRTH_MAX, 3, max neighbour count giving birth
- GP_SURV_MIN, 2, min neighbour count keeping a live cell alive
- GP_SURV_MAX, 3, max neighbour count keeping a live cell alive

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  begin generation; sampled in IDLE only
- abort  in  1  synchronous abort to IDLE, no done
- busy  out  1  high from cycle after start until IDLE
- done  out  1  1-cycle pulse at generation end
- rd_en  out  1  current-buffer read strobe
- rd_addr  out  AW  read address, AW=$clog2(GP_W*GP_H), addr=y*GP_W+x
- rd_data  in  1  cell value, valid 1 cycle after rd_en
- wr_en  out  1  next-buffer write strobe
- wr_addr  out  AW  write address
- wr_data  out  1  next cell state
- gen_cnt  out  16  completed generations, wraps at 0xFFFF->0

Behaviour:
- Reset: state IDLE; busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data = 0; gen_cnt=0; x=y=0; count=0.
- States: IDLE, RD, DRAIN, WR, DONE.
- IDLE -> RD on start. In the same transition, clear x, y and count.
- RD lasts 9 cycles with slot k=0..8.
  - Slot 0 reads the centre cell.
  - Slots 1..8 read offsets in fixed order (-1,-1),(0,-1),(+1,-1),(-1,0),(+1,0),(-1,+1),(0,+1),(+1,+1).
  - rd_data for slot k is captured in the following cycle: slot 0 into the centre register, slots 1..8 added to the 4-bit count (0..8).
- DRAIN: 1 cycle, captures slot 8.
- WR: 1 cycle.
  - wr_en=1, wr_addr=current cell.
  - wr_data = centre ? (SURV_MIN<=count<=SURV_MAX) : (BIRTH_MIN<=count<=BIRTH_MAX).
  - Then advance x; on x=GP_W-1, set x=0 and y++.
  - If the cell was last (x=GP_W-1, y=GP_H-1) go to DONE, else go to RD with count cleared.
- DONE: done=1 for 1 cycle, gen_cnt++, then IDLE.
- Timing: fixed 11 cycles per cell; generation = 11*GP_W*GP_H+1 cycles from start accept to done.
- rd_en and wr_en are never high in the same cycle.
- start outside IDLE is ignored, including in the DONE cycle.
- abort in any non-IDLE state goes to IDLE next cycle.
  - Abort suppresses done and any write in that cycle, and gen_cnt is unchanged.
  - abort has priority over a simultaneous WR or DONE.
- rst_n assertion mid-generation returns all outputs to reset values asynchronously. Partial next-buffer contents are undefined.
- Address arithmetic: x/y neighbours computed mod GP_W/GP_H, or bounds-checked (see Optional Feature); no multiply in the loop, y*GP_W maintained as a running row base.

Optional Feature:
- Macro: LIFE_TORUS_WRAP_EN.
- Defined: the grid is toroidal. x-1 at x=0 maps to GP_W-1, x+1 at GP_W-1 maps to 0, and the same applies to y. All 9 slots issue rd_en.
- Undefined: neighbours outside the grid count as dead. The slot still occupies its cycle with rd_en=0, and its capture adds 0, so timing is identical.

Decomposition:
- Package life_pkg holds:
  - state enum typedef
  - neighbour offset table (9 entries of signed dx,dy)
  - count width constant (4)
  - default rule constants
- One sub-module, life_rule: combinational (centre, count) -> next state, parameterised by the four range limits. Instantiated once.

Test Plan:
- Blinker, 5x5 grid, cells (1,2),(2,2),(3,2) live, start -> next buffer holds (2,1),(2,2),(2,3) only; done after 11*25+1=276 cycles; gen_cnt=1.
- Block still life (1,1),(2,1),(1,2),(2,2) on 6x6, two generations -> buffer unchanged, gen_cnt=2.
- Glider on 8x8, run 32 generations, swapping buffers between generations:
  - with LIFE_TORUS_WRAP_EN, the glider returns to its initial pattern;
  - without it, the glider decays to a block at the corner, matching the reference model.
- abort asserted at cycle 100 of a 16x16 run -> IDLE next cycle, no done, gen_cnt unchanged; subsequent start completes normally.
- start pulsed every cycle during a run -> exactly one done per 11*W*H+1 cycles; no write beyond address W*H-1.
- rst_n low for 1 cycle mid-RD -> busy, rd_en, wr_en = 0 immediately; gen_cnt=0; next start completes correctly.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life generation sequencer:
// FSM state encoding, the 9-slot neighbour offset table, the neighbour
// count width and the default birth/survival rule limits.
package life_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_DRAIN,
    ST_WR,
    ST_DONE
  } state_t;

  // Neighbour count holds 0..8.
  localparam int CNT_W = 4;

  // Slot 0 is the centre cell, slots 1..8 are the eight neighbours.
  localparam int NB_SLOTS = 9;

  // 2-bit signed offsets: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1.
  localparam logic [1:0] OFF_NEG = 2'b11;
  localparam logic [1:0] OFF_POS = 2'b01;

  // Read order: centre, then (-1,-1),(0,-1),(+1,-1),(-1,0),(+1,0),(-1,+1),(0,+1),(+1,+1).
  localparam logic [1:0] NB_DX [NB_SLOTS] = '{2'b00, 2'b11, 2'b00, 2'b01, 2'b11, 2'b01, 2'b11, 2'b00, 2'b01};
  localparam logic [1:0] NB_DY [NB_SLOTS] = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};

  // Conway B3/S23 defaults.
  localparam int DEF_BIRTH_MIN = 3;
  localparam int DEF_BIRTH_MAX = 3;
  localparam int DEF_SURV_MIN  = 2;
  localparam int DEF_SURV_MAX  = 3;

endpackage

// File: rtl/life_rule.sv
// Combinational birth/survival range rule: a live cell survives when its
// neighbour count lies in [SMIN,SMAX], a dead cell is born when the count
// lies in [BMIN,BMAX].
module life_rule
  import life_pkg::*;
#(
  parameter int BMIN = DEF_BIRTH_MIN,
  parameter int BMAX = DEF_BIRTH_MAX,
  parameter int SMIN = DEF_SURV_MIN,
  parameter int SMAX = DEF_SURV_MAX
) (
  input  logic             centre_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             next_o
);

  localparam logic [CNT_W-1:0] BMIN_C = CNT_W'(BMIN);
  localparam logic [CNT_W-1:0] BMAX_C = CNT_W'(BMAX);
  localparam logic [CNT_W-1:0] SMIN_C = CNT_W'(SMIN);
  localparam logic [CNT_W-1:0] SMAX_C = CNT_W'(SMAX);

  // Select the survival or birth window depending on the current cell state.
  always_comb begin
    if (centre_i) next_o = (count_i >= SMIN_C) && (count_i <= SMAX_C);
    else          next_o = (count_i >= BMIN_C) && (count_i <= BMAX_C);
  end

endmodule

// File: rtl/life_gen_ctrl.sv
// One Game-of-Life generation over a GP_W x GP_H grid: per cell, 9 read
// slots (centre + 8 neighbours), one drain cycle for the last read, one
// write cycle. Fixed 11 cycles per cell regardless of grid edges.
// Optional macro LIFE_TORUS_WRAP_EN: neighbours wrap around the grid edges;
// when undefined, off-grid neighbours are dead and their slot issues no read.
module life_gen_ctrl
  import life_pkg::*;
#(
  parameter int GP_W         = 16,
  parameter int GP_H         = 16,
  parameter int GP_BIRTH_MIN = DEF_BIRTH_MIN,
  parameter int GP_BIRTH_MAX = DEF_BIRTH_MAX,
  parameter int GP_SURV_MIN  = DEF_SURV_MIN,
  parameter int GP_SURV_MAX  = DEF_SURV_MAX
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [$clog2(GP_W*GP_H)-1:0]  rd_addr,
  input  logic                          rd_data,
  output logic                          wr_en,
  output logic [$clog2(GP_W*GP_H)-1:0]  wr_addr,
  output logic                          wr_data,
  output logic [15:0]                   gen_cnt
);

  localparam int AW = $clog2(GP_W*GP_H);
  localparam int XW = $clog2(GP_W);
  localparam int YW = $clog2(GP_H);
  localparam logic [XW-1:0] X_LAST    = XW'(GP_W-1);
  localparam logic [YW-1:0] Y_LAST    = YW'(GP_H-1);
  localparam logic [AW-1:0] ROW_STEP  = AW'(GP_W);
  localparam logic [3:0]    SLOT_LAST = 4'(NB_SLOTS-1);
`ifdef LIFE_TORUS_WRAP_EN
  localparam logic [AW-1:0] ROW_LAST  = AW'((GP_H-1)*GP_W);
`endif

  state_t           state_q, state_d;
  logic [3:0]       slot_q, slot_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [AW-1:0]    row_q, row_d;      // running y*GP_W
  logic [CNT_W-1:0] count_q, count_d;
  logic             centre_q, centre_d;
  logic [15:0]      gen_cnt_q, gen_cnt_d;
  // Describe last cycle's read so its data can be captured this cycle.
  logic             cap_en_q, cap_centre_q, cap_rd_q;

  logic [1:0]       dx, dy;
  logic             nb_in;
  logic [XW-1:0]    nb_x;
  logic [AW-1:0]    nb_row, nb_addr, cur_addr;
  logic             rule_next;

  assign nb_addr  = nb_row + AW'(nb_x);
  assign cur_addr = row_q + AW'(x_q);

  life_rule #(
    .BMIN(GP_BIRTH_MIN),
    .BMAX(GP_BIRTH_MAX),
    .SMIN(GP_SURV_MIN),
    .SMAX(GP_SURV_MAX)
  ) u_rule (
    .centre_i(centre_q),
    .count_i (count_q),
    .next_o  (rule_next)
  );

  // Neighbour coordinate for the current slot, wrapped or bounds-checked.
  always_comb begin
    dx     = NB_DX[slot_q];
    dy     = NB_DY[slot_q];
    nb_in  = 1'b1;
    nb_x   = x_q;
    nb_row = row_q;
    if (dx == OFF_NEG) begin
      if (x_q == '0) begin
`ifdef LIFE_TORUS_WRAP_EN
        nb_x = X_LAST;
`else
        nb_in = 1'b0;
`endif
      end else begin
        nb_x = x_q - XW'(1);
      end
    end else if (dx == OFF_POS) begin
      if (x_q == X_LAST) begin
`ifdef LIFE_TORUS_WRAP_EN
        nb_x = '0;
`else
        nb_in = 1'b0;
`endif
      end else begin
        nb_x = x_q + XW'(1);
      end
    end
    if (dy == OFF_NEG) begin
      if (y_q == '0) begin
`ifdef LIFE_TORUS_WRAP_EN
        nb_row = ROW_LAST;
`else
        nb_in = 1'b0;
`endif
      end else begin
        nb_row = row_q - ROW_STEP;
      end
    end else if (dy == OFF_POS) begin
      if (y_q == Y_LAST) begin
`ifdef LIFE_TORUS_WRAP_EN
        nb_row = '0;
`else
        nb_in = 1'b0;
`endif
      end else begin
        nb_row = row_q + ROW_STEP;
      end
    end
  end

  // Next-state logic: read-data capture, cell/slot sequencing, abort override.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    x_d       = x_q;
    y_d       = y_q;
    row_d     = row_q;
    count_d   = count_q;
    centre_d  = centre_q;
    gen_cnt_d = gen_cnt_q;
    if (cap_en_q) begin
      if (cap_centre_q)  centre_d = rd_data;
      else if (cap_rd_q) count_d  = count_q + CNT_W'(rd_data);
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RD;
          slot_d  = '0;
          x_d     = '0;
          y_d     = '0;
          row_d   = '0;
          count_d = '0;
        end
      end
      ST_RD: begin
        if (slot_q == SLOT_LAST) state_d = ST_DRAIN;
        else                     slot_d  = slot_q + 4'd1;
      end
      ST_DRAIN: state_d = ST_WR;
      ST_WR: begin
        slot_d  = '0;
        count_d = '0;
        if (x_q == X_LAST) begin
          x_d   = '0;
          y_d   = y_q + YW'(1);
          row_d = row_q + ROW_STEP;
        end else begin
          x_d = x_q + XW'(1);
        end
        state_d = (x_q == X_LAST && y_q == Y_LAST) ? ST_DONE : ST_RD;
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        gen_cnt_d = gen_cnt_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over everything, including the WR write and the DONE count.
    if (abort && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      gen_cnt_d = gen_cnt_q;
    end
  end

  // Outputs decode from state; abort masks the write and done in its own cycle.
  always_comb begin
    busy    = (state_q != ST_IDLE);
    rd_en   = (state_q == ST_RD) && nb_in;
    rd_addr = rd_en ? nb_addr : '0;
    wr_en   = (state_q == ST_WR) && !abort;
    wr_addr = wr_en ? cur_addr : '0;
    wr_data = wr_en && rule_next;
    done    = (state_q == ST_DONE) && !abort;
    gen_cnt = gen_cnt_q;
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      row_q        <= '0;
      count_q      <= '0;
      centre_q     <= 1'b0;
      gen_cnt_q    <= '0;
      cap_en_q     <= 1'b0;
      cap_centre_q <= 1'b0;
      cap_rd_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      x_q          <= x_d;
      y_q          <= y_d;
      row_q        <= row_d;
      count_q      <= count_d;
      centre_q     <= centre_d;
      gen_cnt_q    <= gen_cnt_d;
      cap_en_q     <= (state_q == ST_RD);
      cap_centre_q <= (state_q == ST_RD) && (slot_q == '0);
      cap_rd_q     <= rd_en;
    end
  end

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Directed bench for life_gen_ctrl on an 8x8 grid with a 1-cycle-latency
// RAM model for the current buffer and a write-capturing next buffer.
module tb_life_gen_ctrl;

  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;
  localparam int GEN_CYC = 11 * N + 1;
  localparam int BUDGET  = GEN_CYC + 100;

  localparam logic [N-1:0] BLINK0 = 64'h0000_0000_000E_0000; // (1,2),(2,2),(3,2)
  localparam logic [N-1:0] BLINK1 = 64'h0000_0000_0404_0400; // (2,1),(2,2),(2,3)
  localparam logic [N-1:0] BLOCK  = 64'h0000_0000_0006_0600; // (1,1),(2,1),(1,2),(2,2)
  localparam logic [N-1:0] GLIDER = 64'h0000_0000_0007_0402; // (1,0),(2,1),(0,2),(1,2),(2,2)
  localparam logic [N-1:0] PAT    = 64'hA5C3_1E7F_0F96_3C5A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, rd_en, rd_data, wr_en, wr_data;
  logic [5:0]  rd_addr, wr_addr;
  logic [15:0] gen_cnt;

  logic [N-1:0] cur_g;
  logic [N-1:0] nxt_g;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_gen = 0;
  int wr_cnt = 0;
  int wr_bad = 0;
  int wr_idx = 0;
  int done_pulses = 0;
  int overlap = 0;

  life_gen_ctrl #(.GP_W(W), .GP_H(H)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .gen_cnt(gen_cnt)
  );

  always #5 clk = ~clk;

  // Buffer RAM models plus protocol monitors.
  always @(posedge clk) begin
    if (rd_en) rd_data <= cur_g[rd_addr];
    if (rd_en && wr_en) overlap <= overlap + 1;
    if (done) done_pulses <= done_pulses + 1;
    if (wr_en) begin
      nxt_g[wr_addr] <= wr_data;
      wr_cnt <= wr_cnt + 1;
      if (int'(wr_addr) != wr_idx) wr_bad <= wr_bad + 1;
      wr_idx <= (wr_idx == N - 1) ? 0 : wr_idx + 1;
    end else if (!busy) begin
      wr_idx <= 0;
    end
  end

  // Reference generation step with default B3/S23 rule.
  function automatic logic [N-1:0] life_step(input logic [N-1:0] g);
    logic [N-1:0] r;
    int n, xx, yy;
    r = '0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        n = 0;
        for (int ddy = -1; ddy <= 1; ddy++) begin
          for (int ddx = -1; ddx <= 1; ddx++) begin
            if (ddx != 0 || ddy != 0) begin
              xx = x + ddx;
              yy = y + ddy;
`ifdef LIFE_TORUS_WRAP_EN
              xx = (xx + W) % W;
              yy = (yy + H) % H;
              n += int'(g[yy*W+xx]);
`else
              if (xx >= 0 && xx < W && yy >= 0 && yy < H) n += int'(g[yy*W+xx]);
`endif
            end
          end
        end
        r[y*W+x] = g[y*W+x] ? (n == 2 || n == 3) : (n == 3);
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic begin_run();
    start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
  endtask

  // Runs one generation; cycles = count from start cycle to done cycle, -1 on timeout.
  task automatic run_gen(input bit spam, output int cycles);
    bit seen;
    seen = 1'b0;
    cycles = 0;
    start = 1'b1;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (!spam) start = 1'b0;
      if (done) seen = 1'b1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    if (!seen) cycles = -1;
    $display("gen: cycles=%0d gen_cnt=%0d", cycles, gen_cnt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, rd_en, wr_en, wr_data} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 00000", {busy, done, rd_en, wr_en, wr_data});
    end
    checks++;
    if (rd_addr !== 6'd0 || wr_addr !== 6'd0) begin
      failures++;
      $display("FAIL reset_addr: got rd=%0d wr=%0d required 0", rd_addr, wr_addr);
    end
    checks++;
    if (gen_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_gen_cnt: got %0d required 0", gen_cnt);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_blinker();
    int c, w0;
    cur_g = BLINK0;
    w0 = wr_cnt;
    run_gen(1'b0, c);
    exp_gen++;
    checks++;
    if (c != GEN_CYC) begin
      failures++;
      $display("FAIL blinker_latency: got %0d required %0d", c, GEN_CYC);
    end
    checks++;
    if (nxt_g !== BLINK1) begin
      failures++;
      $display("FAIL blinker_grid: got %h required %h", nxt_g, BLINK1);
    end
    checks++;
    if (wr_cnt - w0 != N) begin
      failures++;
      $display("FAIL blinker_writes: got %0d required %0d", wr_cnt - w0, N);
    end
    checks++;
    if (int'(gen_cnt) != exp_gen) begin
      failures++;
      $display("FAIL blinker_gen_cnt: got %0d required %0d", gen_cnt, exp_gen);
    end
  endtask

  task automatic test_block();
    int c;
    cur_g = BLOCK;
    for (int g = 0; g < 2; g++) begin
      run_gen(1'b0, c);
      exp_gen++;
      checks++;
      if (nxt_g !== BLOCK) begin
        failures++;
        $display("FAIL block_grid: gen %0d got %h required %h", g, nxt_g, BLOCK);
      end
      cur_g = nxt_g;
    end
    checks++;
    if (int'(gen_cnt) != exp_gen) begin
      failures++;
      $display("FAIL block_gen_cnt: got %0d required %0d", gen_cnt, exp_gen);
    end
  endtask

  task automatic test_pattern();
    int c;
    logic [N-1:0] expv;
    cur_g = PAT;
    expv = life_step(PAT);
    run_gen(1'b0, c);
    exp_gen++;
    checks++;
    if (nxt_g !== expv) begin
      failures++;
      $display("FAIL pattern_grid: got %h required %h", nxt_g, expv);
    end
  endtask

  task automatic test_glider();
    int c;
    logic [N-1:0] model;
    cur_g = GLIDER;
    model = GLIDER;
    for (int g = 0; g < 32; g++) begin
      run_gen(1'b0, c);
      exp_gen++;
      model = life_step(model);
      checks++;
      if (nxt_g !== model) begin
        failures++;
        $display("FAIL glider_gen: gen %0d got %h required %h", g + 1, nxt_g, model);
      end
      cur_g = nxt_g;
    end
`ifdef LIFE_TORUS_WRAP_EN
    checks++;
    if (nxt_g !== GLIDER) begin
      failures++;
      $display("FAIL glider_return: got %h required %h", nxt_g, GLIDER);
    end
`endif
    checks++;
    if (int'(gen_cnt) != exp_gen) begin
      failures++;
      $display("FAIL glider_gen_cnt: got %0d required %0d", gen_cnt, exp_gen);
    end
  endtask

  task automatic test_abort();
    int c, d0, w0;
    cur_g = BLINK0;
    // Abort mid-RD at cycle 100.
    d0 = done_pulses;
    begin_run();
    while (cyc < 100) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      failures++;
      $display("FAIL abort_rd_idle: got busy=%b rd_en=%b required 0 0", busy, rd_en);
    end
    repeat (5) step();
    checks++;
    if (done_pulses != d0 || int'(gen_cnt) != exp_gen) begin
      failures++;
      $display("FAIL abort_rd_nodone: got done=%0d gen=%0d required %0d %0d", done_pulses - d0, gen_cnt, 0, exp_gen);
    end
    // Abort coinciding with the first WR cycle (cycle 11).
    begin_run();
    while (cyc < 11) step();
    checks++;
    if (wr_en !== 1'b1) begin
      failures++;
      $display("FAIL first_wr_cycle: got wr_en=%b required 1", wr_en);
    end
    abort = 1'b1;
    #1;
    checks++;
    if (wr_en !== 1'b0) begin
      failures++;
      $display("FAIL abort_wr_mask: got wr_en=%b required 0", wr_en);
    end
    w0 = wr_cnt;
    step();
    abort = 1'b0;
    checks++;
    if (wr_cnt != w0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_wr_idle: got writes=%0d busy=%b required 0 0", wr_cnt - w0, busy);
    end
    // Abort coinciding with the DONE cycle.
    d0 = done_pulses;
    begin_run();
    while (!done && cyc < BUDGET) step();
    checks++;
    if (cyc != GEN_CYC) begin
      failures++;
      $display("FAIL abort_done_reach: got %0d required %0d", cyc, GEN_CYC);
    end
    abort = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL abort_done_mask: got done=%b required 0", done);
    end
    step();
    abort = 1'b0;
    checks++;
    if (done_pulses != d0 || int'(gen_cnt) != exp_gen || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_done_cnt: got done=%0d gen=%0d busy=%b required 0 %0d 0", done_pulses - d0, gen_cnt, busy, exp_gen);
    end
    // Normal run afterwards.
    run_gen(1'b0, c);
    exp_gen++;
    checks++;
    if (c != GEN_CYC || nxt_g !== BLINK1 || int'(gen_cnt) != exp_gen) begin
      failures++;
      $display("FAIL abort_recover: got cyc=%0d grid=%h gen=%0d required %0d %h %0d", c, nxt_g, gen_cnt, GEN_CYC, BLINK1, exp_gen);
    end
  endtask

  task automatic test_start_spam();
    int c, d0;
    cur_g = BLINK0;
    d0 = done_pulses;
    run_gen(1'b1, c);
    exp_gen++;
    checks++;
    if (c != GEN_CYC) begin
      failures++;
      $display("FAIL spam_latency: got %0d required %0d", c, GEN_CYC);
    end
    checks++;
    if (done_pulses - d0 != 1) begin
      failures++;
      $display("FAIL spam_done_count: got %0d required 1", done_pulses - d0);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL spam_done_start_ignored: got busy=%b required 0", busy);
    end
    checks++;
    if (nxt_g !== BLINK1 || int'(gen_cnt) != exp_gen) begin
      failures++;
      $display("FAIL spam_result: got %h gen=%0d required %h %0d", nxt_g, gen_cnt, BLINK1, exp_gen);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    cur_g = BLINK0;
    begin_run();
    while (cyc < 5) step();
    rst_n = 1'b0;
    #1;
    exp_gen = 0;
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs: got busy=%b rd_en=%b wr_en=%b required 0 0 0", busy, rd_en, wr_en);
    end
    checks++;
    if (gen_cnt !== 16'd0) begin
      failures++;
      $display("FAIL midreset_gen_cnt: got %0d required 0", gen_cnt);
    end
    step();
    rst_n = 1'b1;
    step();
    run_gen(1'b0, c);
    exp_gen++;
    checks++;
    if (c != GEN_CYC || nxt_g !== BLINK1 || int'(gen_cnt) != exp_gen) begin
      failures++;
      $display("FAIL midreset_recover: got cyc=%0d grid=%h gen=%0d required %0d %h %0d", c, nxt_g, gen_cnt, GEN_CYC, BLINK1, exp_gen);
    end
  endtask

  initial begin
    cur_g = '0;
    test_reset();
    test_blinker();
    test_block();
    test_pattern();
    test_glider();
    test_abort();
    test_start_spam();
    test_reset_mid();
    checks++;
    if (overlap != 0) begin
      failures++;
      $display("FAIL rd_wr_overlap: got %0d required 0", overlap);
    end
    checks++;
    if (wr_bad != 0) begin
      failures++;
      $display("FAIL wr_addr_order: got %0d bad writes required 0", wr_bad);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
